// File: rtl/video_scaler_config_scheduler.sv
// Shadow/active configuration store for the aggregate scaler, with a frame-boundary commit that drains outstanding chunks first.
// Optional VIDEO_SCALER_CONFIG_READBACK_EN adds a combinational shadow readback port cfgReadData.
module video_scaler_config_scheduler #(
    parameter int CHUNK_BITS          = 5,
    parameter int SCALE_FRACTION_BITS = 6,
    parameter int OUTSTANDING_BITS    = 12
) (
    input  logic                         scalerClock,
    input  logic                         reset,
    input  logic                         cfgWriteEnable,
    input  logic [3:0]                   cfgAddress,
    input  logic [15:0]                  cfgWriteData,
    input  logic                         commitRequest,
    output logic                         commitPending,
    output logic                         commitDone,
    output logic                         overflowError,
    input  logic                         rawRequestFifoEmpty,
    input  logic [16:0]                  rawRequestFifoReadData,
    output logic                         scalerRequestFifoEmpty,
    input  logic                         scalerRequestFifoReadEnable,
    input  logic                         scalerResponseFifoWriteEnable,
    output logic [10:0]                  cropRows,
    output logic [5:0]                   cropChunks,
    output logic [10:0]                  padTopRows,
    output logic [10:0]                  padLeftColumns,
    output logic [10:0]                  sourceRows,
    output logic [10:0]                  sourceColumns,
    output logic [15:0]                  padColor,
    output logic                         enableBinning,
    output logic [2:0]                   hScaleFactor,
    output logic [2:0]                   vScaleFactor,
    output logic [SCALE_FRACTION_BITS:0] hShrinkFactor,
    output logic [SCALE_FRACTION_BITS:0] vShrinkFactor,
    output logic [15:0]                  backgroundColor,
    output logic                         hScanlineEnable,
    output logic                         vScanlineEnable,
    output logic [1:0]                   scanlineIntensity
`ifdef VIDEO_SCALER_CONFIG_READBACK_EN
    ,
    output logic [15:0]                  cfgReadData
`endif
);

    localparam int SW = SCALE_FRACTION_BITS + 1;
    localparam int CW = OUTSTANDING_BITS;
    localparam int CHUNK_PIXELS = 1 << CHUNK_BITS;
    localparam logic [SW-1:0] UNITY_SHRINK = {1'b1, {SCALE_FRACTION_BITS{1'b0}}};

    typedef struct packed {
        logic [10:0]   crop_rows;
        logic [5:0]    crop_chunks;
        logic [10:0]   pad_top_rows;
        logic [10:0]   pad_left_columns;
        logic [10:0]   source_rows;
        logic [10:0]   source_columns;
        logic [15:0]   pad_color;
        logic          enable_binning;
        logic          h_scanline_enable;
        logic          v_scanline_enable;
        logic [1:0]    scanline_intensity;
        logic [2:0]    h_scale;
        logic [2:0]    v_scale;
        logic [SW-1:0] h_shrink;
        logic [SW-1:0] v_shrink;
        logic [15:0]   background_color;
    } cfg_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DRAIN,
        COMMIT
    } state_t;

    function automatic cfg_t cfg_defaults();
        cfg_t c;
        c          = '0;
        c.h_scale  = 3'd1;
        c.v_scale  = 3'd1;
        c.h_shrink = UNITY_SHRINK;
        c.v_shrink = UNITY_SHRINK;
        return c;
    endfunction

    cfg_t          shadow;
    cfg_t          active;
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW:0]   count_wide;
    logic          saturate;
    logic          frame_start;
    logic          hold;
    logic          pop;

    // Frame start is the (row 0, chunk 0) request sitting at the FIFO head.
    assign frame_start = !rawRequestFifoEmpty && (rawRequestFifoReadData == '0);
    assign hold        = ((state == ARMED) && frame_start) || (state == DRAIN) || (state == COMMIT);
    assign scalerRequestFifoEmpty = rawRequestFifoEmpty || hold;
    assign pop         = scalerRequestFifoReadEnable && !scalerRequestFifoEmpty;

    // NOTE: shadow and active sets are plain flops rather than a RAM, so every field takes its reset value asynchronously.
    always_ff @(posedge scalerClock or negedge reset) begin
        if (!reset) begin
            shadow <= cfg_defaults();
        end else if (cfgWriteEnable) begin
            // NOTE: non-blocking updates mean a write in the COMMIT cycle is not seen by the copy below.
            case (cfgAddress)
                4'd0:  shadow.crop_rows        <= cfgWriteData[10:0];
                4'd1:  shadow.crop_chunks      <= cfgWriteData[5:0];
                4'd2:  shadow.pad_top_rows     <= cfgWriteData[10:0];
                4'd3:  shadow.pad_left_columns <= cfgWriteData[10:0];
                4'd4:  shadow.source_rows      <= cfgWriteData[10:0];
                4'd5:  shadow.source_columns   <= cfgWriteData[10:0];
                4'd6:  shadow.pad_color        <= cfgWriteData;
                4'd7: begin
                    shadow.enable_binning     <= cfgWriteData[4];
                    shadow.h_scanline_enable  <= cfgWriteData[3];
                    shadow.v_scanline_enable  <= cfgWriteData[2];
                    shadow.scanline_intensity <= cfgWriteData[1:0];
                end
                4'd8: begin
                    shadow.h_scale <= cfgWriteData[5:3];
                    shadow.v_scale <= cfgWriteData[2:0];
                end
                4'd9:  shadow.h_shrink         <= cfgWriteData[SW-1:0];
                4'd10: shadow.v_shrink         <= cfgWriteData[SW-1:0];
                4'd11: shadow.background_color <= cfgWriteData;
                default: ;
            endcase
        end
    end

    always_ff @(posedge scalerClock or negedge reset) begin
        if (!reset) begin
            active <= cfg_defaults();
        end else if (state == COMMIT) begin
            active <= shadow;
        end
    end

    // Increment before decrement so a simultaneous pop and response nets +CHUNK_PIXELS-1.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        count_wide = {1'b0, count};
        if (pop) begin
            count_wide = count_wide + (CW + 1)'(CHUNK_PIXELS);
        end
        if (scalerResponseFifoWriteEnable && (count_wide != '0)) begin
            count_wide = count_wide - 1'b1;
        end
        saturate   = count_wide[CW];
        count_next = saturate ? '1 : count_wide[CW-1:0];
    end

    always_ff @(posedge scalerClock or negedge reset) begin
        if (!reset) begin
            count         <= '0;
            overflowError <= 1'b0;
        end else begin
            count <= count_next;
            if (saturate) begin
                overflowError <= 1'b1;
            end
        end
    end

    always_ff @(posedge scalerClock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        commitPending = 1'b0;
        commitDone    = 1'b0;
        case (state)
            IDLE: begin
                if (commitRequest) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                commitPending = 1'b1;
                if (frame_start) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                commitPending = 1'b1;
                if (count == '0) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commitPending = 1'b1;
                commitDone    = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign cropRows          = active.crop_rows;
    assign cropChunks        = active.crop_chunks;
    assign padTopRows        = active.pad_top_rows;
    assign padLeftColumns    = active.pad_left_columns;
    assign sourceRows        = active.source_rows;
    assign sourceColumns     = active.source_columns;
    assign padColor          = active.pad_color;
    assign enableBinning     = active.enable_binning;
    assign hScaleFactor      = active.h_scale;
    assign vScaleFactor      = active.v_scale;
    assign hShrinkFactor     = active.h_shrink;
    assign vShrinkFactor     = active.v_shrink;
    assign backgroundColor   = active.background_color;
    assign hScanlineEnable   = active.h_scanline_enable;
    assign vScanlineEnable   = active.v_scanline_enable;
    assign scanlineIntensity = active.scanline_intensity;

`ifdef VIDEO_SCALER_CONFIG_READBACK_EN
    always_comb begin
        cfgReadData = '0;
        case (cfgAddress)
            4'd0:  cfgReadData = 16'(shadow.crop_rows);
            4'd1:  cfgReadData = 16'(shadow.crop_chunks);
            4'd2:  cfgReadData = 16'(shadow.pad_top_rows);
            4'd3:  cfgReadData = 16'(shadow.pad_left_columns);
            4'd4:  cfgReadData = 16'(shadow.source_rows);
            4'd5:  cfgReadData = 16'(shadow.source_columns);
            4'd6:  cfgReadData = shadow.pad_color;
            4'd7:  cfgReadData = {11'd0, shadow.enable_binning, shadow.h_scanline_enable,
                                  shadow.v_scanline_enable, shadow.scanline_intensity};
            4'd8:  cfgReadData = {10'd0, shadow.h_scale, shadow.v_scale};
            4'd9:  cfgReadData = 16'(shadow.h_shrink);
            4'd10: cfgReadData = 16'(shadow.v_shrink);
            4'd11: cfgReadData = shadow.background_color;
            default: cfgReadData = '0;
        endcase
    end
`endif

endmodule

// File: tb/tb_video_scaler_config_scheduler.sv
// Self-checking bench: register-file/queue reference model, directed commit scenarios and randomized traffic.
module tb_video_scaler_config_scheduler;

    localparam int MAX_COUNT  = (1 << 12) - 1;
    localparam int PH_IDLE    = 0;
    localparam int PH_WAIT    = 1;
    localparam int PH_DRAIN   = 2;
    localparam int PH_COMMIT  = 3;
    localparam logic [15:0] FIELD_MASK [12] = '{16'h07FF, 16'h003F, 16'h07FF, 16'h07FF, 16'h07FF, 16'h07FF,
                                                16'hFFFF, 16'h001F, 16'h003F, 16'h007F, 16'h007F, 16'hFFFF};

    logic        scalerClock = 1'b0;
    logic        reset;
    logic        cfgWriteEnable;
    logic [3:0]  cfgAddress;
    logic [15:0] cfgWriteData;
    logic        commitRequest;
    logic        rawRequestFifoEmpty;
    logic [16:0] rawRequestFifoReadData;
    logic        scalerRequestFifoReadEnable;
    logic        scalerResponseFifoWriteEnable;

    logic        commitPending, commitDone, overflowError, scalerRequestFifoEmpty;
    logic [10:0] cropRows, padTopRows, padLeftColumns, sourceRows, sourceColumns;
    logic [5:0]  cropChunks;
    logic [15:0] padColor, backgroundColor;
    logic        enableBinning, hScanlineEnable, vScanlineEnable;
    logic [2:0]  hScaleFactor, vScaleFactor;
    logic [6:0]  hShrinkFactor, vShrinkFactor;
    logic [1:0]  scanlineIntensity;

    logic        s_commitPending, s_commitDone, s_overflowError, s_scalerRequestFifoEmpty;
    logic [10:0] s_cropRows, s_padTopRows, s_padLeftColumns, s_sourceRows, s_sourceColumns;
    logic [5:0]  s_cropChunks;
    logic [15:0] s_padColor, s_backgroundColor;
    logic        s_enableBinning, s_hScanlineEnable, s_vScanlineEnable;
    logic [2:0]  s_hScaleFactor, s_vScaleFactor;
    logic [6:0]  s_hShrinkFactor, s_vShrinkFactor;
    logic [1:0]  s_scanlineIntensity;

    always #5 scalerClock = ~scalerClock;

    video_scaler_config_scheduler dut (
        .scalerClock(scalerClock), .reset(reset),
        .cfgWriteEnable(cfgWriteEnable), .cfgAddress(cfgAddress), .cfgWriteData(cfgWriteData),
        .commitRequest(commitRequest), .commitPending(commitPending), .commitDone(commitDone),
        .overflowError(overflowError), .rawRequestFifoEmpty(rawRequestFifoEmpty),
        .rawRequestFifoReadData(rawRequestFifoReadData), .scalerRequestFifoEmpty(scalerRequestFifoEmpty),
        .scalerRequestFifoReadEnable(scalerRequestFifoReadEnable),
        .scalerResponseFifoWriteEnable(scalerResponseFifoWriteEnable),
        .cropRows(cropRows), .cropChunks(cropChunks), .padTopRows(padTopRows),
        .padLeftColumns(padLeftColumns), .sourceRows(sourceRows), .sourceColumns(sourceColumns),
        .padColor(padColor), .enableBinning(enableBinning), .hScaleFactor(hScaleFactor),
        .vScaleFactor(vScaleFactor), .hShrinkFactor(hShrinkFactor), .vShrinkFactor(vShrinkFactor),
        .backgroundColor(backgroundColor), .hScanlineEnable(hScanlineEnable),
        .vScanlineEnable(vScanlineEnable), .scanlineIntensity(scanlineIntensity)
    );

    // Narrow-counter instance for the saturation scenario; shares every input with the main instance.
    video_scaler_config_scheduler #(.OUTSTANDING_BITS(6)) dut_small (
        .scalerClock(scalerClock), .reset(reset),
        .cfgWriteEnable(cfgWriteEnable), .cfgAddress(cfgAddress), .cfgWriteData(cfgWriteData),
        .commitRequest(commitRequest), .commitPending(s_commitPending), .commitDone(s_commitDone),
        .overflowError(s_overflowError), .rawRequestFifoEmpty(rawRequestFifoEmpty),
        .rawRequestFifoReadData(rawRequestFifoReadData), .scalerRequestFifoEmpty(s_scalerRequestFifoEmpty),
        .scalerRequestFifoReadEnable(scalerRequestFifoReadEnable),
        .scalerResponseFifoWriteEnable(scalerResponseFifoWriteEnable),
        .cropRows(s_cropRows), .cropChunks(s_cropChunks), .padTopRows(s_padTopRows),
        .padLeftColumns(s_padLeftColumns), .sourceRows(s_sourceRows), .sourceColumns(s_sourceColumns),
        .padColor(s_padColor), .enableBinning(s_enableBinning), .hScaleFactor(s_hScaleFactor),
        .vScaleFactor(s_vScaleFactor), .hShrinkFactor(s_hShrinkFactor), .vShrinkFactor(s_vShrinkFactor),
        .backgroundColor(s_backgroundColor), .hScanlineEnable(s_hScanlineEnable),
        .vScanlineEnable(s_vScanlineEnable), .scanlineIntensity(s_scanlineIntensity)
    );

    int          checks = 0;
    int          errors = 0;
    logic [16:0] req_q[$];
    logic [15:0] m_shadow [12];
    logic [15:0] m_active [12];
    int          m_count;
    bit          m_ovf;
    int          m_phase;
    bit          last_empty;
    bit          last_done;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 12; i++) m_shadow[i] = 16'h0000;
        m_shadow[8]  = 16'h0009;
        m_shadow[9]  = 16'h0040;
        m_shadow[10] = 16'h0040;
        m_active = m_shadow;
        m_count  = 0;
        m_ovf    = 1'b0;
        m_phase  = PH_IDLE;
    endtask

    function automatic logic [117:0] exp_cfg();
        return {m_active[0][10:0], m_active[1][5:0], m_active[2][10:0], m_active[3][10:0],
                m_active[4][10:0], m_active[5][10:0], m_active[6], m_active[7][4],
                m_active[8][5:3], m_active[8][2:0], m_active[9][6:0], m_active[10][6:0],
                m_active[11], m_active[7][3], m_active[7][2], m_active[7][1:0]};
    endfunction

    task automatic clear_strobes();
        cfgWriteEnable = 1'b0;
        cfgAddress = 4'd0;
        cfgWriteData = 16'h0000;
        commitRequest = 1'b0;
        scalerRequestFifoReadEnable = 1'b0;
        scalerResponseFifoWriteEnable = 1'b0;
    endtask

    task automatic drive_raw();
        rawRequestFifoEmpty    = (req_q.size() == 0);
        rawRequestFifoReadData = (req_q.size() == 0) ? 17'd0 : req_q[0];
    endtask

    task automatic check_outputs(output bit exp_empty, output bit fs);
        bit hold;
        fs = (req_q.size() > 0) && (req_q[0] == 17'd0);
        hold = ((m_phase == PH_WAIT) && fs) || (m_phase == PH_DRAIN) || (m_phase == PH_COMMIT);
        exp_empty = (req_q.size() == 0) || hold;
        last_empty = scalerRequestFifoEmpty;
        last_done  = commitDone;
        check("req_empty", scalerRequestFifoEmpty, exp_empty);
        check("pending", commitPending, m_phase != PH_IDLE);
        check("done", commitDone, m_phase == PH_COMMIT);
        check("overflow", overflowError, m_ovf);
        check("active_cfg",
              {cropRows, cropChunks, padTopRows, padLeftColumns, sourceRows, sourceColumns, padColor,
               enableBinning, hScaleFactor, vScaleFactor, hShrinkFactor, vShrinkFactor,
               backgroundColor, hScanlineEnable, vScanlineEnable, scanlineIntensity}, exp_cfg());
    endtask

    // One clock: apply inputs, check, then advance the model to what the next edge should produce.
    task automatic cycle();
        bit exp_empty, fs, pop;
        int nxt;
        drive_raw();
        #1;
        check_outputs(exp_empty, fs);
        pop = scalerRequestFifoReadEnable && !exp_empty;
        nxt = m_count + (pop ? 32 : 0);
        if (scalerResponseFifoWriteEnable && nxt > 0) nxt--;
        if (nxt > MAX_COUNT) begin
            nxt = MAX_COUNT;
            m_ovf = 1'b1;
        end
        case (m_phase)
            PH_IDLE:   if (commitRequest) m_phase = PH_WAIT;
            PH_WAIT:   if (fs) m_phase = PH_DRAIN;
            PH_DRAIN:  if (m_count == 0) m_phase = PH_COMMIT;
            default: begin
                m_active = m_shadow;
                m_phase  = PH_IDLE;
            end
        endcase
        if (cfgWriteEnable && cfgAddress < 4'd12) m_shadow[cfgAddress] = cfgWriteData & FIELD_MASK[cfgAddress];
        if (pop) void'(req_q.pop_front());
        m_count = nxt;
        @(negedge scalerClock);
        clear_strobes();
    endtask

    task automatic do_reset();
        bit exp_empty, fs;
        clear_strobes();
        reset = 1'b0;
        drive_raw();
        #1;
        model_reset();
        check_outputs(exp_empty, fs);
        @(negedge scalerClock);
        reset = 1'b1;
    endtask

    task automatic write_reg(input logic [3:0] addr, input logic [15:0] data);
        cfgWriteEnable = 1'b1;
        cfgAddress = addr;
        cfgWriteData = data;
        cycle();
    endtask

    // Pulse commit, return every outstanding pixel, and optionally write padColor during COMMIT.
    task automatic commit_and_drain(input string tag, input int exp_rsp, input bit late_write);
        int n_rsp = 0;
        bit seen = 1'b0;
        commitRequest = 1'b1;
        cycle();
        for (int i = 0; i < 400 && !seen; i++) begin
            if (late_write && m_phase == PH_COMMIT) begin
                cfgWriteEnable = 1'b1;
                cfgAddress = 4'd6;
                cfgWriteData = 16'h1234;
            end
            scalerResponseFifoWriteEnable = (m_count > 0);
            if (m_count > 0) n_rsp++;
            cycle();
            seen = last_done;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_responses"}, n_rsp, exp_rsp);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        clear_strobes();
        drive_raw();
        @(negedge scalerClock);

        // Reset defaults, with and without a request at the raw FIFO head.
        do_reset();
        check("rst_hscale", hScaleFactor, 3'd1);
        check("rst_vshrink", vShrinkFactor, 7'd64);
        check("rst_croprows", cropRows, 11'd0);
        req_q.push_back(17'h00123);
        do_reset();
        check("rst_empty_follows_raw", scalerRequestFifoEmpty, 1'b0);
        req_q.delete();

        // Shadow isolation across 1000 frame starts.
        write_reg(4'd0, 16'd8);
        for (int i = 0; i < 1000; i++) begin
            req_q.push_back(17'd0);
            scalerRequestFifoReadEnable = 1'b1;
            scalerResponseFifoWriteEnable = (m_count > 0);
            cycle();
        end
        check("iso_croprows", cropRows, 11'd0);
        check("iso_saturated", overflowError, 1'b1);
        req_q.delete();
        do_reset();

        // Commit with two chunks outstanding.
        write_reg(4'd8, 16'h0019);
        req_q.push_back(17'h00040);
        req_q.push_back(17'h00041);
        for (int i = 0; i < 2; i++) begin
            scalerRequestFifoReadEnable = 1'b1;
            cycle();
        end
        req_q.push_back(17'd0);
        req_q.push_back(17'h00042);
        commit_and_drain("drain", 64, 1'b0);
        check("drain_hscale", hScaleFactor, 3'd3);
        check("drain_vscale", vScaleFactor, 3'd1);
        scalerRequestFifoReadEnable = 1'b1;
        cycle();
        check("drain_release", last_empty, 1'b0);
        check("done_one_cycle", last_done, 1'b0);

        // Simultaneous pop and response: 32 -> 63.
        scalerRequestFifoReadEnable = 1'b1;
        scalerResponseFifoWriteEnable = 1'b1;
        cycle();
        req_q.push_back(17'd0);
        commit_and_drain("simul", 63, 1'b0);

        // Write landing in the COMMIT cycle waits for the next commit.
        write_reg(4'd6, 16'h00AA);
        commit_and_drain("late_wr1", 0, 1'b1);
        check("late_wr_old", padColor, 16'h00AA);
        commit_and_drain("late_wr2", 0, 1'b0);
        check("late_wr_new", padColor, 16'h1234);

        // Reset in the middle of a drain.
        req_q.delete();
        req_q.push_back(17'h00055);
        scalerRequestFifoReadEnable = 1'b1;
        cycle();
        req_q.push_back(17'd0);
        commitRequest = 1'b1;
        cycle();
        cycle();
        cycle();
        check("midrst_pre_pending", commitPending, 1'b1);
        do_reset();
        check("midrst_empty", scalerRequestFifoEmpty, 1'b0);
        check("midrst_pending", commitPending, 1'b0);

        // Saturation on the 6-bit counter instance.
        req_q.delete();
        for (int i = 0; i < 3; i++) req_q.push_back(17'h00100 + 17'(i));
        for (int i = 0; i < 3; i++) begin
            scalerRequestFifoReadEnable = 1'b1;
            cycle();
        end
        check("ovf_small", s_overflowError, 1'b1);
        check("ovf_main_clear", overflowError, 1'b0);
        for (int i = 0; i < 5; i++) cycle();
        check("ovf_small_sticky", s_overflowError, 1'b1);
        do_reset();
        check("ovf_small_reset", s_overflowError, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            if (req_q.size() < 6 && $urandom_range(0, 3) == 0)
                req_q.push_back(($urandom_range(0, 4) == 0) ? 17'd0 : 17'($urandom_range(1, 17'h1FFFF)));
            scalerRequestFifoReadEnable = ($urandom_range(0, 9) == 0) && (m_count < 3000);
            scalerResponseFifoWriteEnable = (m_count > 0) ? ($urandom_range(0, 3) != 0)
                                                          : ($urandom_range(0, 7) == 0);
            cfgWriteEnable = ($urandom_range(0, 3) == 0);
            cfgAddress = 4'($urandom_range(0, 15));
            cfgWriteData = 16'($urandom);
            commitRequest = ($urandom_range(0, 24) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
